uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } uart_tx_state_t;

  // Clocks per bit period, rounded to nearest.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the registered count, so a same-cycle pop never frees space for a push.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage write; no reset needed on the data array.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: START/DATA writes fill a FIFO, the serializer
// drains it as 8N1 frames on TX, LSB first.
// Optional: define UART_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | line high; pops the head byte when FIFO non-empty
// START_BIT  | line low for one bit period
// DATA_BITS  | shift register LSB on line, 8 bit periods
// PARITY_BIT | even parity of the byte (UART_PARITY_EN only)
// STOP_BIT   | line high for one bit period, then back to IDLE
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [UART_DATA_W-1:0] DATA,
  output logic                   READY,
  output logic                   TX,
  output logic                   BUSY,
  output logic                   OVF
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t         state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCW-1:0]         fifo_count;
  logic                   pop;
  logic                   bit_done;
`ifdef UART_PARITY_EN
  logic                   parity;
`endif

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push    (START),
    .wr_data (DATA),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pop      = (state == IDLE) && !fifo_empty;
  assign bit_done = (baud_cnt == CNT_LAST);
  assign READY    = !fifo_full;
  assign BUSY     = (state != IDLE) || (fifo_count != '0);

  // Sticky overflow: a write arrived while the FIFO was full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 OVF <= 1'b0;
    else if (START && fifo_full) OVF <= 1'b1;
  end

  // Serializer FSM; TX is registered and updated on each state change.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
`ifdef UART_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          TX       <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift   <= head;
            bit_idx <= '0;
            state   <= START_BIT;
            TX      <= 1'b0;
`ifdef UART_PARITY_EN
            parity  <= ^head;
`endif
          end
        end
        START_BIT: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= DATA_BITS;
            TX       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA_BITS: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY_BIT;
              TX    <= parity;
`else
              state <= STOP_BIT;
              TX    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              TX      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        PARITY_BIT: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= STOP_BIT;
            TX       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        STOP_BIT: begin
          if (bit_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            TX       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
          state    <= IDLE;
          TX       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed an expected-byte queue, a
// line monitor decodes frames from TX and compares against the queue.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * 10;
  localparam int STOP_J    = (FRAME_BITS - 1) * 10 + 5;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic [7:0] DATA;
  logic       READY;
  logic       TX;
  logic       BUSY;
  logic       OVF;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int frames_rx = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];

  logic [7:0] mon_d;
  logic [7:0] mon_exp;
  logic       mon_start;
  logic       mon_par;
  logic       mon_stop;
  bit         mon_abort;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .DATA  (DATA),
    .READY (READY),
    .TX    (TX),
    .BUSY  (BUSY),
    .OVF   (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; drives one START pulse covering the next rising edge.
  task automatic push(input logic [7:0] b, input bit accept, output int e);
    START = 1'b1;
    DATA  = b;
    e     = cyc + 1;
    if (accept) exp_q.push_back(b);
    @(negedge CLK);
    START = 1'b0;
    DATA  = 8'h00;
  endtask

  task automatic wait_after(input int e);
    while (cyc < e) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: BUSY still 1 after %0d cycles", n);
    end
    repeat (3) @(negedge CLK);
  endtask

  // Line monitor: decodes each frame by sampling mid-bit on negedges.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N && mon_en && TX === 1'b0) begin
        mon_abort = 1'b0;
        mon_start = 1'b0;
        mon_par   = 1'b0;
        mon_stop  = 1'b0;
        mon_d     = 8'h00;
        for (int j = 1; j < FRAME_CYC; j++) begin
          @(negedge CLK);
          if (!RST_N) begin
            mon_abort = 1'b1;
            break;
          end
          if (j == 5) mon_start = TX;
          if (j >= 15 && j <= 85 && (j % 10) == 5) mon_d[(j - 15) / 10] = TX;
          if (j == 95) mon_par = TX;
          if (j == STOP_J) mon_stop = TX;
        end
        if (!mon_abort) begin
          frames_rx++;
          chk("frame_start_bit", mon_start, 0);
          chk("frame_stop_bit", mon_stop, 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_unexpected: got byte %0h expected no frame", mon_d);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("frame_data", mon_d, mon_exp);
`ifdef UART_PARITY_EN
            chk("frame_parity", mon_par, ^mon_exp);
`endif
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, g, f0;
    START = 1'b0;
    DATA  = 8'h00;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", TX, 1);
    chk("rst_ready", READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVF, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single byte A5: start low from edge n+1, bits LSB first.
    push(8'hA5, 1, e);
    chk("a5_pre_tx", TX, 1);
    chk("a5_pre_busy", BUSY, 1);
    wait_after(e + 1);  chk("a5_start_first", TX, 0);
    wait_after(e + 10); chk("a5_start_last", TX, 0);
    wait_after(e + 11); chk("a5_bit0", TX, 1);
    wait_after(e + 21); chk("a5_bit1", TX, 0);
    wait_after(e + 31); chk("a5_bit2", TX, 1);
    wait_after(e + FRAME_CYC);     chk("a5_stop_tx", TX, 1);
    chk("a5_stop_busy", BUSY, 1);
    wait_after(e + FRAME_CYC + 1); chk("a5_done_busy", BUSY, 0);
    wait_idle();

    // Back-to-back 55, 0F: one idle cycle between frames.
    push(8'h55, 1, e);
    push(8'h0F, 1, e2);
    wait_after(e + FRAME_CYC);     chk("b2b_stop", TX, 1);
    wait_after(e + FRAME_CYC + 1); chk("b2b_gap", TX, 1);
    wait_after(e + FRAME_CYC + 2); chk("b2b_second_start", TX, 0);
    wait_idle();

    // Parity vectors: 07 has odd popcount, 03 even.
    push(8'h07, 1, e);
    wait_after(e + 95); chk("p07_bit8_slot", TX, 1);
    wait_idle();
    push(8'h03, 1, e);
    wait_after(e + 95);
`ifdef UART_PARITY_EN
    chk("p03_bit8_slot", TX, 0);
`else
    chk("p03_bit8_slot", TX, 1);
`endif
    wait_idle();

    // Reset mid-frame: TX returns high asynchronously.
    mon_en = 1'b0;
    push(8'h00, 0, e);
    wait_after(e + 30);
    chk("midrst_pre_tx", TX, 0);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_tx", TX, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_ready", READY, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_post_busy", BUSY, 0);
    chk("midrst_post_tx", TX, 1);
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Full: 11 pops immediately; 22..55 fill the FIFO; 66 is dropped.
    f0 = frames_rx;
    push(8'h11, 1, e);
    push(8'h22, 1, e);
    push(8'h33, 1, e);
    push(8'h44, 1, e);
    chk("full_ready_3", READY, 1);
    push(8'h55, 1, e);
    chk("full_ready_4", READY, 0);
    chk("full_ovf_pre", OVF, 0);
    push(8'h66, 0, e);
    chk("full_ovf", OVF, 1);
    chk("full_ready_drop", READY, 0);
    wait_idle();
    chk("full_frames", frames_rx - f0, 5);

    // Boundary: START on the same edge as the pop from a full FIFO.
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rst2_ovf", OVF, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    push(8'hB0, 1, g);
    push(8'hC1, 1, e);
    push(8'hC2, 1, e);
    push(8'hC3, 1, e);
    push(8'hC4, 1, e);
    wait_after(g + FRAME_CYC + 1);
    chk("bnd_ready_full", READY, 0);
    chk("bnd_ovf_pre", OVF, 0);
    push(8'hDD, 0, e);
    chk("bnd_ready_after_pop", READY, 1);
    chk("bnd_ovf", OVF, 1);
    chk("bnd_tx_start", TX, 0);
    wait_idle();

    // Refill to exercise pointer wrap again.
    push(8'hE1, 1, e);
    push(8'hE2, 1, e);
    push(8'hE3, 1, e);
    push(8'hE4, 1, e);
    wait_idle();

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
